// File: rtl/tdes_ede_encrypt_pkg.sv
// Shared constants for the TDES EDE encrypt block: FSM states, DES mode codes, widths and the
// DES permutation / S-box tables with the bit-level helpers used by the iterative core.
package tdes_ede_encrypt_pkg;

  localparam int unsigned BLK_W = 64;
  localparam int unsigned KEY_W = 64;

  localparam logic DES_ENC = 1'b0;
  localparam logic DES_DEC = 1'b1;

  typedef enum logic [2:0] {
    StIdle, StP1St, StP1Wt, StP2St, StP2Wt, StP3St, StP3Wt, StHold
  } state_e;

  // Tables use FIPS 46 numbering: entry n names the source bit (1 = MSB) of output bit n+1.
  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int unsigned E_TAB [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int unsigned P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27,
    19, 11, 3, 60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S1..S8, each 64 nibbles in row-major order (row = outer bits, column = inner four bits).
  localparam logic [0:2047] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [1:64] ip_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IP_TAB[i-1]];
    return y;
  endfunction

  function automatic logic [1:64] fp_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[FP_TAB[i-1]];
    return y;
  endfunction

  function automatic logic [1:56] pc1_perm(input logic [1:64] k);
    logic [1:56] y;
    for (int i = 1; i <= 56; i++) y[i] = k[PC1_TAB[i-1]];
    return y;
  endfunction

  function automatic logic [1:48] pc2_perm(input logic [1:56] cd);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = cd[PC2_TAB[i-1]];
    return y;
  endfunction

  // Rotates C and D halves; left for encryption, right to walk the schedule backwards.
  function automatic logic [1:56] rot_cd(input logic [1:56] cd, input logic dec,
                                         input logic [1:0] amt);
    logic [27:0] c, d;
    c = cd[1:28];
    d = cd[29:56];
    for (int i = 0; i < 2; i++) begin
      if (i < int'(amt)) begin
        if (dec) begin
          c = {c[0], c[27:1]};
          d = {d[0], d[27:1]};
        end else begin
          c = {c[26:0], c[27]};
          d = {d[26:0], d[27]};
        end
      end
    end
    return {c, d};
  endfunction

  function automatic logic [1:32] des_f(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s, y;
    logic [5:0]  b;
    int          idx;
    for (int i = 1; i <= 48; i++) x[i] = r[E_TAB[i-1]] ^ k[i];
    for (int n = 0; n < 8; n++) begin
      b   = x[n*6+1 +: 6];
      idx = n*256 + 4*(32*int'(b[5]) + 16*int'(b[0]) + int'(b[4:1]));
      s[n*4+1 +: 4] = SBOX[idx +: 4];
    end
    for (int i = 1; i <= 32; i++) y[i] = s[P_TAB[i-1]];
    return y;
  endfunction

endpackage

// File: rtl/state_encrypt.sv
// Iterative DES core: one round per clock, 17 cycles from the ready pulse to the out_ok pulse.
// mode selects encrypt (0) or decrypt (1); ct holds the result from out_ok until the next run.
module state_encrypt
  import tdes_ede_encrypt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             mode,
  input  logic [1:KEY_W]   key,
  input  logic [1:BLK_W]   din,
  output logic [1:BLK_W]   ct,
  output logic             out_ok
);

  logic [1:64] lr_q, lr_d;
  logic [1:56] cd_q, cd_d;
  logic [3:0]  rnd_q;
  logic        run_q, mode_q;
  logic [1:0]  amt;

  // Decrypt starts on K16 (CD unrotated) and rotates right by the mirrored schedule.
  always_comb begin
    if (mode_q == DES_ENC) begin
      amt = (rnd_q inside {4'd0, 4'd1, 4'd8, 4'd15}) ? 2'd1 : 2'd2;
    end else if (rnd_q == 4'd0) begin
      amt = 2'd0;
    end else begin
      amt = (rnd_q inside {4'd1, 4'd8, 4'd15}) ? 2'd1 : 2'd2;
    end
    cd_d = rot_cd(cd_q, mode_q, amt);
    lr_d = {lr_q[33:64], lr_q[1:32] ^ des_f(lr_q[33:64], pc2_perm(cd_d))};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_q   <= '0;
      cd_q   <= '0;
      rnd_q  <= '0;
      run_q  <= 1'b0;
      mode_q <= DES_ENC;
      ct     <= '0;
      out_ok <= 1'b0;
    end else begin
      out_ok <= 1'b0;
      if (ready) begin
        lr_q   <= ip_perm(din);
        cd_q   <= pc1_perm(key);
        mode_q <= mode;
        rnd_q  <= '0;
        run_q  <= 1'b1;
      end else if (run_q) begin
        lr_q  <= lr_d;
        cd_q  <= cd_d;
        rnd_q <= rnd_q + 4'd1;
        if (rnd_q == 4'd15) begin
          run_q  <= 1'b0;
          out_ok <= 1'b1;
          ct     <= fp_perm({lr_d[33:64], lr_d[1:32]});
        end
      end
    end
  end

endmodule

// File: rtl/tdes_ede_encrypt.sv
// Triple-DES EDE encrypt, ct = E(K1, D(K2, E(K1, pt))), three passes through one DES core.
// Define TDES_3KEY_EN to add a key3 port used for the third pass instead of key1.
module tdes_ede_encrypt
  import tdes_ede_encrypt_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:BLK_W]   in_data,
  input  logic [1:KEY_W]   key1,
  input  logic [1:KEY_W]   key2,
`ifdef TDES_3KEY_EN
  input  logic [1:KEY_W]   key3,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:BLK_W]   out_data,
  output logic             busy
);

  state_e         state_q, state_d;
  logic [1:BLK_W] pt_q, work_q;
  logic [1:KEY_W] k1_q, k2_q, k_last;
  logic           core_ready, core_mode, core_ok;
  logic [1:KEY_W] core_key;
  logic [1:BLK_W] core_din, core_ct;

`ifdef TDES_3KEY_EN
  logic [1:KEY_W] k3_q;
  assign k_last = k3_q;
`else
  assign k_last = k1_q;
`endif

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    core_ready = 1'b0;
    core_mode  = DES_ENC;
    core_key   = k1_q;
    core_din   = work_q;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = StP1St;
      end
      StP1St: begin
        core_din   = pt_q;
        core_ready = 1'b1;
        state_d    = StP1Wt;
      end
      StP1Wt: begin
        core_din = pt_q;
        if (core_ok) state_d = StP2St;
      end
      StP2St: begin
        core_mode  = DES_DEC;
        core_key   = k2_q;
        core_ready = 1'b1;
        state_d    = StP2Wt;
      end
      StP2Wt: begin
        core_mode = DES_DEC;
        core_key  = k2_q;
        if (core_ok) state_d = StP3St;
      end
      StP3St: begin
        core_key   = k_last;
        core_ready = 1'b1;
        state_d    = StP3Wt;
      end
      StP3Wt: begin
        core_key = k_last;
        if (core_ok) state_d = StHold;
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pt_q    <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      work_q  <= '0;
`ifdef TDES_3KEY_EN
      k3_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        pt_q <= in_data;
        k1_q <= key1;
        k2_q <= key2;
`ifdef TDES_3KEY_EN
        k3_q <= key3;
`endif
      end
      // A done pulse outside a wait state is stray and must not disturb the result.
      if (core_ok && (state_q inside {StP1Wt, StP2Wt, StP3Wt})) work_q <= core_ct;
    end
  end

  assign out_data = work_q;

  state_encrypt u_core (
    .clk    (clk),
    .reset  (reset),
    .ready  (core_ready),
    .mode   (core_mode),
    .key    (core_key),
    .din    (core_din),
    .ct     (core_ct),
    .out_ok (core_ok)
  );

endmodule

// File: tb/tb_tdes_ede_encrypt.sv
// Bench for tdes_ede_encrypt: known-answer, round-trip, backpressure, key churn, mid-flight
// reset and random blocks checked against a subkey-array DES reference model.
module tb_tdes_ede_encrypt;
  import tdes_ede_encrypt_pkg::*;

  localparam int CoreL = 17;
  localparam int Lat   = 3 * (CoreL + 1) + 1;
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:64] in_data, key1, key2, out_data;
`ifdef TDES_3KEY_EN
  logic [1:64] key3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tdes_ede_encrypt dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key1      (key1),
    .key2      (key2),
`ifdef TDES_3KEY_EN
    .key3      (key3),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Textbook DES: build all 16 subkeys first, then walk them forwards or backwards.
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                          input bit dec);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [47:0] e;
    logic [63:0] x, pre, res;
    logic [31:0] l, r, f, s, t;
    logic [5:0]  six;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TAB[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < SHIFTS[n]; j++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][47-i] = cd[56-PC2_TAB[i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = blk[64-IP_TAB[i]];
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_TAB[i]];
      e = e ^ ks[dec ? 15 - n : n];
      for (int sb = 0; sb < 8; sb++) begin
        six = e[47-6*sb -: 6];
        s[31-4*sb -: 4] = SBOX[sb*256 + 4*(32*int'(six[5]) + 16*int'(six[0])
                                           + int'(six[4:1])) +: 4];
      end
      for (int i = 0; i < 32; i++) f[31-i] = s[32-P_TAB[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_TAB[i]];
    return res;
  endfunction

  function automatic logic [63:0] tdes_enc_ref(input logic [63:0] pt, input logic [63:0] k1,
                                               input logic [63:0] k2, input logic [63:0] k3);
    return des_ref(k3, des_ref(k2, des_ref(k1, pt, 1'b0), 1'b1), 1'b0);
  endfunction

  function automatic logic [63:0] tdes_dec_ref(input logic [63:0] ct, input logic [63:0] k1,
                                               input logic [63:0] k2, input logic [63:0] k3);
    return des_ref(k1, des_ref(k2, des_ref(k3, ct, 1'b1), 1'b0), 1'b1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One block end to end; ports are scrambled while in flight to prove they were captured.
  task automatic run_block(input logic [63:0] pt, input logic [63:0] k1, input logic [63:0] k2,
                           input logic [63:0] k3, input int hold, output logic [63:0] ct);
    logic [63:0] exp, k_last;
    int          n;
`ifdef TDES_3KEY_EN
    key3   = k3;
    k_last = k3;
`else
    k_last = k1;
`endif
    in_data  = pt;
    key1     = k1;
    key2     = k2;
    in_valid = 1'b1;
    check("acc_rdy", 64'(in_ready), 64'd1);
    tick();
    n = 1;
    while (!out_valid && n < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rnd64();
      key1     = rnd64();
      key2     = rnd64();
`ifdef TDES_3KEY_EN
      key3     = rnd64();
`endif
      if (n == 30) begin
        check("fly_busy", 64'(busy), 64'd1);
        check("fly_rdy", 64'(in_ready), 64'd0);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    exp = tdes_enc_ref(pt, k1, k2, k_last);
    check("latency", 64'(n), 64'(Lat));
    check("data", out_data, exp);
    ct = out_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_vld", 64'(out_valid), 64'd1);
      check("hold_data", out_data, exp);
      check("hold_rdy", 64'(in_ready), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rdy", 64'(in_ready), 64'd1);
    check("post_vld", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] ct, pt, k1, k2, k3;
    int          n_hi;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    key1      = '0;
    key2      = '0;
`ifdef TDES_3KEY_EN
    key3      = '0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", out_data, 64'd0);

    // Equal keys collapse EDE to single DES.
    k1 = 64'h133457799BBCDFF1;
    run_block(64'h0123456789ABCDEF, k1, k1, k1, 0, ct);
    check("kat", ct, 64'h85E813540F0AB405);

    pt = 64'h5468652071756663;
    k1 = 64'h0123456789ABCDEF;
    k2 = 64'h23456789ABCDEF01;
    run_block(pt, k1, k2, k1, 2, ct);
    check("roundtrip", tdes_dec_ref(ct, k1, k2, k1), pt);
    check("two_key", ct, tdes_enc_ref(pt, k1, k2, k1));

    run_block(rnd64(), rnd64(), rnd64(), rnd64(), 10, ct);

    for (int i = 0; i < 6; i++) begin
      pt = rnd64();
      k1 = rnd64();
      k2 = rnd64();
      k3 = rnd64();
      run_block(pt, k1, k2, k3, $urandom_range(0, 3), ct);
`ifdef TDES_3KEY_EN
      check("rand_rtrip", tdes_dec_ref(ct, k1, k2, k3), pt);
`else
      check("rand_rtrip", tdes_dec_ref(ct, k1, k2, k1), pt);
`endif
    end

    // Abort in the middle of the second pass.
    in_data  = 64'h0123456789ABCDEF;
    key1     = 64'h133457799BBCDFF1;
    key2     = 64'h133457799BBCDFF1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (25) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_vld", 64'(out_valid), 64'd0);
    check("abort_rdy", 64'(in_ready), 64'd1);
    n_hi = 0;
    repeat (60) begin
      tick();
      if (out_valid) n_hi++;
    end
    check("abort_quiet", 64'(n_hi), 64'd0);
    k1 = 64'h133457799BBCDFF1;
    run_block(64'h0123456789ABCDEF, k1, k1, k1, 0, ct);
    check("abort_kat", ct, 64'h85E813540F0AB405);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
